mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Upstream neighbour of the 128 KB byte-wide on-board RAM.
- Accepts 32-bit instruction-fetch and load/store requests from the CPU core.
- Arbitrates between them and serializes each access into 1, 2 or 4 byte transactions on the RAM's single-port synchronous byte interface.
- Reassembles read bytes little-endian and pulses a per-requester done.

Parameters:
- ADDR_WIDTH, 32, width of all address ports (RAM consumes low 17 bits).
- IO_SEL, 2'b11, value of addr[17:16] that marks the IO region (used only with IO_STALL_EN).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous and active-high.
- rdy_in  input  1  global ready; low freezes all state.
- clear_in  input  1  abort any in-flight instruction fetch (mispredict).
- io_buffer_full_in  input  1  UART TX buffer full.
- mem_din  input  8  RAM read data.
- mem_dout  output  8  RAM write data.
- mem_a  output  ADDR_WIDTH  RAM byte address.
- mem_wr  output  1  1 = write, 0 = read.
- if_req_in  input  1  fetch request, level, held until done.
- if_addr_in  input  ADDR_WIDTH  fetch address.
- if_done_out  output  1  one-cycle fetch completion.
- if_data_out  output  32  fetched word.
- ls_req_in  input  1  load/store request, level.
- ls_we_in  input  1  1 = store.
- ls_size_in  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- ls_addr_in  input  ADDR_WIDTH  load/store address.
- ls_wdata_in  input  32  store data, little-endian, low bytes used.
- ls_done_out  output  1  one-cycle load/store completion.
- ls_rdata_out  output  32  load data, zero-extended.

Behaviour:
- Reset (async, rst_in=1): state IDLE; all outputs 0 (mem_a, mem_dout, mem_wr, both done, both data); byte counters 0.
- States:
  - IDLE, READ, WRITE.
  - IO_WAIT only when IO_STALL_EN is defined.
- n = byte count: 1, 2 or 4 (fetch always 4).
- Arbitration: in IDLE, when no done is high this cycle, LSU wins over IF.
  - The request is accepted at edge E0; addr, size, wdata and owner are latched.
  - Requests are ignored during a done cycle; the requester drops req in its done cycle.
- Read:
  - mem_a = addr+k is registered at E(k), k = 0..n-1; mem_wr = 0.
  - The RAM responds one cycle later, so byte k is captured from mem_din at E(k+2) into bits [8k+7:8k].
  - At E(n+1): the owner's done_out = 1, data_out is valid, state returns to IDLE.
  - A 4-byte read has done visible 5 cycles after acceptance.
- Write:
  - mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr = 1 are registered at E(k), k = 0..n-1.
  - At E(n): mem_wr = 0, ls_done_out = 1, state returns to IDLE.
- Addresses add with 32-bit wrap; no alignment check.
- In IDLE: mem_a, mem_dout and mem_wr are 0.
- data_out retains its last value after done.
- done is high exactly one cycle.
- rdy_in = 0: no state, counter or output register changes. A held write re-presents the same byte, which is idempotent. Processing resumes exactly where it left off.
- clear_in = 1:
  - If the active owner is IF, return to IDLE at the next edge; no if_done_out; mem_wr stays 0.
  - If the owner is LSU, clear_in is ignored.
  - In IDLE, if_req_in is not accepted while clear_in = 1.
- Async reset mid-operation abandons the transaction immediately; no done is issued.

Optional Feature:
- Macro: IO_STALL_EN.
- Defined: a store whose latched addr[17:16] == IO_SEL and that finds io_buffer_full_in = 1 at the edge where it would drive mem_wr = 1 enters IO_WAIT.
  - IO_WAIT drives mem_wr = 0 and holds mem_a.
  - It re-enters WRITE at the first edge with io_buffer_full_in = 0.
  - done is delayed by the number of stalled cycles.
- Undefined: io_buffer_full_in is ignored and the IO_WAIT state does not exist.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum (IDLE/READ/WRITE/IO_WAIT);
  - size encodings SZ_B/SZ_H/SZ_W;
  - owner encoding OWN_IF/OWN_LS;
  - IO_SEL default.
- Single module. Arbitration, counter and byte assembly are inline; no sub-module is warranted.

Test Plan:
- Preload RAM 0x100..0x103 = 13,05,00,93; IF req addr 0x100 -> mem_a 0x100..0x103 on successive cycles, if_done_out 5 cycles after acceptance, if_data_out = 0x93000513.
- Same cycle: IF req 0x0 and LS byte load 0x200 (RAM = 0xFF) -> LSU served first, ls_rdata_out = 0x000000FF, then IF served.
- LS half store 0x1FFFE, wdata 0xAABBCCDD -> bytes DD at 0x1FFFE and CC at 0x1FFFF, mem_wr high exactly 2 cycles, ls_done after 2 cycles; readback half = 0x0000CCDD.
- IF fetch in flight, clear_in pulsed after byte 1 -> no if_done_out, IDLE next cycle, a subsequent LS load completes normally.
- rdy_in low 3 cycles in the middle of a word load -> mem_a frozen, result identical to the unstalled load, done 3 cycles later.
- IO_STALL_EN: byte store to 0x30000 with io_buffer_full_in high 4 cycles -> mem_wr stays 0 during the stall, then one write, ls_done 4 cycles late.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and encodings for the memory controller.
//   state_e     controller states (StIoWait exists only with IO_STALL_EN defined)
//   owner_e     which requester owns the current transaction
//   SZ_*        load/store size encodings
//   byte_count  size encoding -> number of RAM byte transactions
// Optional feature macro: IO_STALL_EN.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
`ifdef IO_STALL_EN
        , StIoWait
`endif
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Size 3 is treated as a word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates CPU instruction-fetch and load/store requests onto the
// single-port synchronous byte-wide RAM, serialising each access into 1, 2 or 4
// byte transactions and reassembling read data little-endian.
//   clk_in, rst_in (async, active-high), rdy_in (global freeze), clear_in (fetch abort)
//   io_buffer_full_in           UART TX full (only used with IO_STALL_EN)
//   mem_din/mem_dout/mem_a/mem_wr   RAM byte interface
//   if_req_in/if_addr_in -> if_done_out/if_data_out   instruction fetch port
//   ls_req_in/ls_we_in/ls_size_in/ls_addr_in/ls_wdata_in -> ls_done_out/ls_rdata_out
// Optional feature macro: IO_STALL_EN (stall IO-region stores while the UART is full).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [1:0]  IO_SEL     = IO_SEL_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  io_buffer_full_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  ls_req_in,
    input  logic                  ls_we_in,
    input  logic [1:0]            ls_size_in,
    input  logic [ADDR_WIDTH-1:0] ls_addr_in,
    input  logic [31:0]           ls_wdata_in,
    output logic                  ls_done_out,
    output logic [31:0]           ls_rdata_out
);

    state_e                r_state, w_state;
    owner_e                r_owner, w_owner;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr, r_mem_a, w_mem_a, w_addr_next;
    logic [2:0]            r_n, w_n, r_step, w_step, w_step_inc;
    logic [31:0]           r_wdata, w_wdata, r_buf, w_buf;
    logic [31:0]           r_if_data, w_if_data, r_ls_data, w_ls_data;
    logic [7:0]            r_mem_dout, w_mem_dout, r_din_hold, w_din;
    logic                  r_mem_wr, w_mem_wr, r_if_done, w_if_done, r_ls_done, w_ls_done;
    logic                  r_was_rdy;
    logic [1:0]            w_cap_idx;

    // r_step is the number of edges since acceptance; byte k is addressed at step k
    // and its data is captured two edges later.
    assign w_step_inc  = r_step + 3'd1;
    assign w_addr_next = r_addr + ADDR_WIDTH'(w_step_inc);
    assign w_cap_idx   = 2'(w_step_inc - 3'd2);

    // The RAM keeps clocking while rdy_in is low, so the byte it returned just before
    // a freeze is overwritten. Snapshot it so capture resumes with the right byte.
    assign w_din = r_was_rdy ? mem_din : r_din_hold;

`ifdef IO_STALL_EN
    logic w_io_stall_new, w_io_stall_cur;
    assign w_io_stall_new = (ls_addr_in[17:16] == IO_SEL) && io_buffer_full_in;
    assign w_io_stall_cur = (r_addr[17:16] == IO_SEL) && io_buffer_full_in;
`else
    // Without the stall feature the UART flag and IO region select have no effect.
    logic w_unused_io;
    assign w_unused_io = ^{io_buffer_full_in, IO_SEL};
`endif

    always_comb begin
        w_state    = r_state;
        w_owner    = r_owner;
        w_addr     = r_addr;
        w_n        = r_n;
        w_step     = r_step;
        w_wdata    = r_wdata;
        w_buf      = r_buf;
        w_mem_a    = r_mem_a;
        w_mem_dout = r_mem_dout;
        w_mem_wr   = r_mem_wr;
        w_if_done  = 1'b0;
        w_ls_done  = 1'b0;
        w_if_data  = r_if_data;
        w_ls_data  = r_ls_data;

        case (r_state)
            StIdle: begin
                w_mem_a    = '0;
                w_mem_dout = '0;
                w_mem_wr   = 1'b0;
                // Requests are ignored in a done cycle: the requester is still dropping req.
                if (!r_if_done && !r_ls_done) begin
                    if (ls_req_in) begin
                        w_owner = OWN_LS;
                        w_addr  = ls_addr_in;
                        w_n     = byte_count(ls_size_in);
                        w_step  = '0;
                        w_wdata = ls_wdata_in;
                        w_buf   = '0;
                        w_mem_a = ls_addr_in;
                        if (ls_we_in) begin
                            w_state    = StWrite;
                            w_mem_dout = ls_wdata_in[7:0];
                            w_mem_wr   = 1'b1;
`ifdef IO_STALL_EN
                            if (w_io_stall_new) begin
                                w_state  = StIoWait;
                                w_mem_wr = 1'b0;
                            end
`endif
                        end else begin
                            w_state = StRead;
                        end
                    end else if (if_req_in && !clear_in) begin
                        w_owner = OWN_IF;
                        w_addr  = if_addr_in;
                        w_n     = 3'd4;
                        w_step  = '0;
                        w_buf   = '0;
                        w_mem_a = if_addr_in;
                        w_state = StRead;
                    end
                end
            end

            StRead: begin
                if (r_owner == OWN_IF && clear_in) begin
                    w_state = StIdle;
                    w_step  = '0;
                    w_mem_a = '0;
                end else begin
                    w_step = w_step_inc;
                    if (w_step_inc < r_n) begin
                        w_mem_a = w_addr_next;
                    end
                    if (w_step_inc >= 3'd2) begin
                        w_buf[{w_cap_idx, 3'b000} +: 8] = w_din;
                    end
                    if (w_step_inc == r_n + 3'd1) begin
                        w_state = StIdle;
                        w_step  = '0;
                        w_mem_a = '0;
                        if (r_owner == OWN_IF) begin
                            w_if_done = 1'b1;
                            w_if_data = w_buf;
                        end else begin
                            w_ls_done = 1'b1;
                            w_ls_data = w_buf;
                        end
                    end
                end
            end

            StWrite: begin
                if (w_step_inc == r_n) begin
                    w_state    = StIdle;
                    w_step     = '0;
                    w_mem_a    = '0;
                    w_mem_dout = '0;
                    w_mem_wr   = 1'b0;
                    w_ls_done  = 1'b1;
                end else begin
                    w_step     = w_step_inc;
                    w_mem_a    = w_addr_next;
                    w_mem_dout = r_wdata[{w_step_inc[1:0], 3'b000} +: 8];
                    w_mem_wr   = 1'b1;
`ifdef IO_STALL_EN
                    if (w_io_stall_cur) begin
                        w_state  = StIoWait;
                        w_mem_wr = 1'b0;
                    end
`endif
                end
            end

`ifdef IO_STALL_EN
            // mem_a already points at the pending byte; just wait for buffer space.
            StIoWait: begin
                if (!io_buffer_full_in) begin
                    w_state    = StWrite;
                    w_mem_dout = r_wdata[{r_step[1:0], 3'b000} +: 8];
                    w_mem_wr   = 1'b1;
                end
            end
`endif

            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= StIdle;
            r_owner    <= OWN_IF;
            r_addr     <= '0;
            r_n        <= '0;
            r_step     <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= '0;
            r_ls_data  <= '0;
            r_was_rdy  <= 1'b0;
            r_din_hold <= '0;
        end else begin
            r_was_rdy  <= rdy_in;
            r_din_hold <= w_din;
            if (rdy_in) begin
                r_state    <= w_state;
                r_owner    <= w_owner;
                r_addr     <= w_addr;
                r_n        <= w_n;
                r_step     <= w_step;
                r_wdata    <= w_wdata;
                r_buf      <= w_buf;
                r_mem_a    <= w_mem_a;
                r_mem_dout <= w_mem_dout;
                r_mem_wr   <= w_mem_wr;
                r_if_done  <= w_if_done;
                r_ls_done  <= w_ls_done;
                r_if_data  <= w_if_data;
                r_ls_data  <= w_ls_data;
            end
        end
    end

    assign mem_a        = r_mem_a;
    assign mem_dout     = r_mem_dout;
    assign mem_wr       = r_mem_wr;
    assign if_done_out  = r_if_done;
    assign if_data_out  = r_if_data;
    assign ls_done_out  = r_ls_done;
    assign ls_rdata_out = r_ls_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A 128 KB byte RAM model sits on the
// memory port; a separate shadow byte array holds the expected memory contents and
// expected load/fetch results are computed from it. Directed scenarios are followed
// by randomized fetches, loads and stores with random rdy_in freezes.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in, io_buffer_full_in;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req_in, if_done_out;
    logic [31:0] if_addr_in, if_data_out;
    logic        ls_req_in, ls_we_in, ls_done_out;
    logic [1:0]  ls_size_in;
    logic [31:0] ls_addr_in, ls_wdata_in, ls_rdata_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .clear_in         (clear_in),
        .io_buffer_full_in(io_buffer_full_in),
        .mem_din          (mem_din),
        .mem_dout         (mem_dout),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .if_req_in        (if_req_in),
        .if_addr_in       (if_addr_in),
        .if_done_out      (if_done_out),
        .if_data_out      (if_data_out),
        .ls_req_in        (ls_req_in),
        .ls_we_in         (ls_we_in),
        .ls_size_in       (ls_size_in),
        .ls_addr_in       (ls_addr_in),
        .ls_wdata_in      (ls_wdata_in),
        .ls_done_out      (ls_done_out),
        .ls_rdata_out     (ls_rdata_out)
    );

    // RAM: synchronous single port, read data one cycle after the address.
    logic [7:0] ram     [0:131071];
    logic [7:0] ref_mem [0:131071];

    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a[16:0]] <= mem_dout;
        mem_din <= ram[mem_a[16:0]];
    end

    logic [31:0] tr_a  [0:63];
    logic        tr_wr [0:63];
    logic [7:0]  tr_d  [0:63];
    bit          seen_if_done, seen_ls_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[17'(a + 32'(k))];
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int k = 0; k < n; k++) ref_mem[17'(a + 32'(k))] = d[8*k +: 8];
    endtask

    task automatic gap();
        @(posedge clk_in); #1;
    endtask

    // Issue one load/store. e=0 is the acceptance edge. rdy_in is low for edges
    // stall_at+1 .. stall_at+stall_len; io_buffer_full_in is high for edges 0..io_len-1.
    task automatic ls_op(input bit we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall_at, input int stall_len,
                         input int io_len, output logic [31:0] rdata, output int lat);
        bit done;
        ls_req_in = 1'b1; ls_we_in = we; ls_size_in = size;
        ls_addr_in = addr; ls_wdata_in = wdata;
        io_buffer_full_in = (io_len > 0);
        lat = -1; rdata = 'x; done = 1'b0; seen_if_done = 1'b0;
        for (int e = 0; e < 64 && !done; e++) begin
            @(posedge clk_in); #1;
            tr_a[6'(e)] = mem_a; tr_wr[6'(e)] = mem_wr; tr_d[6'(e)] = mem_dout;
            if (if_done_out) seen_if_done = 1'b1;
            if (e == io_len - 1) io_buffer_full_in = 1'b0;
            if (e == stall_at) rdy_in = 1'b0;
            if (e == stall_at + stall_len) rdy_in = 1'b1;
            if (ls_done_out) begin
                done = 1'b1; lat = e; rdata = ls_rdata_out; ls_req_in = 1'b0;
            end
        end
        ls_req_in = 1'b0; rdy_in = 1'b1; io_buffer_full_in = 1'b0;
    endtask

    // Issue one fetch; clear_in is raised after edge clear_at and the request dropped
    // one edge later.
    task automatic if_op(input logic [31:0] addr, input int clear_at,
                         output logic [31:0] data, output int lat, output bit got);
        bit stop;
        if_req_in = 1'b1; if_addr_in = addr;
        lat = -1; data = 'x; got = 1'b0; stop = 1'b0; seen_ls_done = 1'b0;
        for (int e = 0; e < 64 && !stop; e++) begin
            @(posedge clk_in); #1;
            tr_a[6'(e)] = mem_a; tr_wr[6'(e)] = mem_wr; tr_d[6'(e)] = mem_dout;
            if (ls_done_out) seen_ls_done = 1'b1;
            if (if_done_out) begin
                got = 1'b1; stop = 1'b1; lat = e; data = if_data_out; if_req_in = 1'b0;
            end else if (e == clear_at) begin
                clear_in = 1'b1;
            end else if (clear_in) begin
                clear_in = 1'b0; if_req_in = 1'b0; stop = 1'b1; lat = e;
            end
        end
        if_req_in = 1'b0; clear_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, a, wd;
        logic [1:0]  sz;
        int          lat, n, sa, sl, cnt;
        bit          got, we;

        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full_in = 1'b0;
        if_req_in = 1'b0; if_addr_in = '0;
        ls_req_in = 1'b0; ls_we_in = 1'b0; ls_size_in = '0; ls_addr_in = '0; ls_wdata_in = '0;

        for (int i = 0; i < 131072; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h93;
        ram[32'h200] = 8'hFF;
        ref_mem[17'h100] = 8'h13; ref_mem[17'h101] = 8'h05;
        ref_mem[17'h102] = 8'h00; ref_mem[17'h103] = 8'h93;
        ref_mem[17'h200] = 8'hFF;

        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_if_done", 32'(if_done_out), 32'h0);
        chk("rst_ls_done", 32'(ls_done_out), 32'h0);
        chk("rst_if_data", if_data_out, 32'h0);
        chk("rst_ls_data", ls_rdata_out, 32'h0);
        rst_in = 1'b0;
        gap();

        // Word fetch from preloaded program bytes.
        if_op(32'h100, -1, d, lat, got);
        chk("fetch_done", 32'(got), 32'h1);
        chk("fetch_lat", 32'(lat), 32'd5);
        chk("fetch_data", d, 32'h93000513);
        for (int k = 0; k < 4; k++) begin
            chk("fetch_addr_seq", tr_a[6'(k)], 32'h100 + 32'(k));
            chk("fetch_wr_low", 32'(tr_wr[6'(k)]), 32'h0);
        end
        gap();
        chk("done_one_cycle", 32'(if_done_out), 32'h0);
        chk("data_retained", if_data_out, 32'h93000513);

        // Simultaneous fetch and byte load: load goes first.
        if_req_in = 1'b1; if_addr_in = 32'h0;
        ls_op(1'b0, 2'd0, 32'h200, 32'h0, -1, 0, 0, d, lat);
        chk("arb_ls_lat", 32'(lat), 32'd2);
        chk("arb_ls_data", d, 32'h000000FF);
        chk("arb_if_not_first", 32'(seen_if_done), 32'h0);
        if_op(32'h0, -1, d, lat, got);
        chk("arb_if_done", 32'(got), 32'h1);
        chk("arb_if_data", d, ref_read(32'h0, 4));
        gap();

        // Half store across the top of RAM, then read it back.
        ls_op(1'b1, 2'd1, 32'h1FFFE, 32'hAABBCCDD, -1, 0, 0, d, lat);
        ref_write(32'h1FFFE, 2, 32'hAABBCCDD);
        chk("sth_lat", 32'(lat), 32'd2);
        chk("sth_a0", tr_a[0], 32'h1FFFE);
        chk("sth_d0", 32'(tr_d[0]), 32'hDD);
        chk("sth_a1", tr_a[1], 32'h1FFFF);
        chk("sth_d1", 32'(tr_d[1]), 32'hCC);
        chk("sth_wr_cycles", 32'(tr_wr[0]) + 32'(tr_wr[1]) + 32'(tr_wr[2]), 32'd2);
        gap();
        ls_op(1'b0, 2'd1, 32'h1FFFE, 32'h0, -1, 0, 0, d, lat);
        chk("ldh_data", d, 32'h0000CCDD);
        chk("ldh_ref", d, ref_read(32'h1FFFE, 2));
        gap();

        // Fetch aborted by clear after byte 1.
        if_op(32'h100, 1, d, lat, got);
        chk("clr_no_done", 32'(got), 32'h0);
        chk("clr_idle_a", tr_a[2], 32'h0);
        chk("clr_wr_low", 32'(tr_wr[2]), 32'h0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            gap();
            if (if_done_out) cnt++;
        end
        chk("clr_no_late_done", 32'(cnt), 32'h0);
        ls_op(1'b0, 2'd2, 32'h100, 32'h0, -1, 0, 0, d, lat);
        chk("clr_ld_lat", 32'(lat), 32'd5);
        chk("clr_ld_data", d, 32'h93000513);
        gap();

        // Three frozen cycles in the middle of a word load.
        ls_op(1'b0, 2'd2, 32'h100, 32'h0, 1, 3, 0, d, lat);
        chk("rdy_lat", 32'(lat), 32'd8);
        chk("rdy_data", d, 32'h93000513);
        for (int k = 1; k <= 4; k++) chk("rdy_a_frozen", tr_a[6'(k)], 32'h101);
        gap();

        // Byte store to the IO region while the UART buffer is full for 4 cycles.
        ls_op(1'b1, 2'd0, 32'h30000, 32'h0000005A, -1, 0, 4, d, lat);
        ref_write(32'h30000, 1, 32'h0000005A);
`ifdef IO_STALL_EN
        chk("io_lat", 32'(lat), 32'd5);
        for (int k = 0; k < 4; k++) chk("io_wr_stalled", 32'(tr_wr[6'(k)]), 32'h0);
        chk("io_wr", 32'(tr_wr[4]), 32'h1);
        chk("io_a", tr_a[4], 32'h30000);
        chk("io_d", 32'(tr_d[4]), 32'h5A);
`else
        chk("io_ignored_lat", 32'(lat), 32'd1);
        chk("io_ignored_wr", 32'(tr_wr[0]), 32'h1);
`endif
        gap();

        // Async reset mid-load: outputs clear without a clock edge, no done follows.
        ls_req_in = 1'b1; ls_we_in = 1'b0; ls_size_in = 2'd2; ls_addr_in = 32'h100;
        gap();
        gap();
        rst_in = 1'b1;
        #1;
        chk("arst_mem_a", mem_a, 32'h0);
        ls_req_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            gap();
            if (ls_done_out) cnt++;
        end
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gap();
            if (ls_done_out) cnt++;
        end
        chk("arst_no_done", 32'(cnt), 32'h0);

        // Randomized traffic against the shadow memory.
        for (int it = 0; it < 60; it++) begin
            a = ($urandom & 32'hFFFE0000) |
                (($urandom_range(0, 1) == 0) ? 32'h400 + 32'($urandom_range(0, 40))
                                             : 32'h1FFFC + 32'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                if_op(a, -1, d, lat, got);
                chk("rnd_if_lat", 32'(lat), 32'd5);
                chk("rnd_if_data", d, ref_read(a, 4));
            end else begin
                we = 1'($urandom);
                sz = 2'($urandom_range(0, 3));
                wd = $urandom;
                n  = nbytes(sz);
                sa = -1; sl = 0;
                if ($urandom_range(0, 2) == 0) begin
                    sa = $urandom_range(0, n - 1);
                    sl = $urandom_range(1, 4);
                end
                ls_op(we, sz, a, wd, sa, sl, 0, d, lat);
                if (we) begin
                    ref_write(a, n, wd);
                    chk("rnd_st_lat", 32'(lat), 32'(n + sl));
                end else begin
                    chk("rnd_ld_lat", 32'(lat), 32'(n + 1 + sl));
                    chk("rnd_ld_data", d, ref_read(a, n));
                end
            end
            gap();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
